// File: rtl/adder_tree_pkg.sv
// Shared types and constants for the 8-lane adder tree.
// Used by the serial operand loader / result collector.
package adder_tree_pkg;

  localparam int TREE_LANES = 8;
  localparam int SUM_EXTRA  = 3;

  typedef enum logic [1:0] {
    FILL,
    LAUNCH,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/adder_tree_loader.sv
// Serial operand loader and sum collector for the 8-lane adder tree.
// Define ADDER_TREE_LOADER_FLUSH_EN to add in_last for short groups.
module adder_tree_loader
  import adder_tree_pkg::*;
#(
  parameter int WIDTH    = 23,
  parameter int LANES    = 8,
  parameter int TREE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
`ifdef ADDER_TREE_LOADER_FLUSH_EN
  input  logic                       in_last,
`endif
  output logic [LANES*WIDTH-1:0]     ops,
  input  logic [WIDTH+SUM_EXTRA-1:0] tree_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH+SUM_EXTRA-1:0] out_sum
);

  localparam int SW = WIDTH + SUM_EXTRA;

  if (LANES != TREE_LANES) begin : g_bad_lanes
    $error("adder_tree_loader: LANES must be 8");
  end

  state_t state;
  state_t state_nx;

  logic [2:0]                   cnt;
  logic [7:0]                   wcnt;
  logic [LANES-1:0][WIDTH-1:0]  lanes;
  logic                         hs;
  logic                         last_op;
  logic                         tree_done;
  logic                         out_hs;

  assign ops    = lanes;
  assign hs     = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

`ifdef ADDER_TREE_LOADER_FLUSH_EN
  assign last_op = hs && ((cnt == 3'd7) || in_last);
`else
  assign last_op = hs && (cnt == 3'd7);
`endif

  assign tree_done = (state == WAIT) &&
                     (wcnt == 8'(TREE_LAT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  // Next-state: fill, launch, wait out the tree, hold result.
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:    if (last_op)   state_nx = LAUNCH;
      LAUNCH:                 state_nx = WAIT;
      WAIT:    if (tree_done) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = FILL;
      default:                state_nx = FILL;
    endcase
  end

  // Handshake outputs; ready is held low while in reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == FILL): in_ready  = rst_n;
      (state == HOLD): out_valid = 1'b1;
      default: ;
    endcase
  end

  // Lane registers and fill counter; cleared when result leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes <= '0;
      cnt   <= '0;
    end else if (hs) begin
      lanes[cnt] <= in_data;
      cnt        <= cnt + 3'd1;
    end else if (out_hs) begin
      lanes <= '0;
      cnt   <= '0;
    end
  end

  // Tree latency counter, restarted at launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wcnt <= '0;
    else if (state == LAUNCH)  wcnt <= '0;
    else if (state == WAIT)    wcnt <= wcnt + 8'd1;
  end

  // Capture the tree sum once its pipeline has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_sum <= '0;
    else if (tree_done) out_sum <= tree_sum[SW-1:0];
  end

endmodule

// File: tb/tb_adder_tree_loader.sv
// Directed plus randomized bench for adder_tree_loader.
// Includes a behavioural two-stage tree model.
module tb_adder_tree_loader;

  localparam int W  = 23;
  localparam int SW = W + 3;
  localparam int L  = 8;

  typedef logic [W-1:0] op_q_t[$];

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
`ifdef ADDER_TREE_LOADER_FLUSH_EN
  logic           in_last;
`endif
  logic [L*W-1:0] ops;
  logic [SW-1:0]  tree_sum;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_tree_loader #(
    .WIDTH(W), .LANES(L), .TREE_LAT(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef ADDER_TREE_LOADER_FLUSH_EN
    .in_last  (in_last),
`endif
    .ops      (ops),
    .tree_sum (tree_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum)
  );

  // Tree model: input register, then 8-way add into a sum register.
  logic [L*W-1:0] t_in;

  function automatic logic [SW-1:0] lane_sum(
    input logic [L*W-1:0] b);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < L; k++) s += SW'(b[k*W +: W]);
    return s;
  endfunction

  always @(posedge clk) begin
    t_in     <= ops;
    tree_sum <= lane_sum(t_in);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand and wait (bounded) for it to be taken.
  task automatic push(input logic [W-1:0] d, input bit last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
`ifdef ADDER_TREE_LOADER_FLUSH_EN
    in_last  = last;
`else
    if (last) t = 0;
`endif
    while (in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    chk("push_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
`ifdef ADDER_TREE_LOADER_FLUSH_EN
    in_last  = 1'b0;
`endif
    in_data  = W'($urandom);
  endtask

  // Load a group, check the bundle, latency and captured sum.
  task automatic run_group(input string tag,
                           input op_q_t d,
                           input int gap,
                           input bit use_last,
                           output logic [SW-1:0] exp);
    int lat;
    exp = '0;
    foreach (d[i]) exp += SW'(d[i]);
    foreach (d[i]) begin
      push(d[i], use_last && (i == d.size() - 1));
      if (i != d.size() - 1)
        repeat (gap) tick();
    end
    for (int k = 0; k < L; k++)
      chk({tag, "_lane"},
          64'(ops[k*W +: W]),
          (k < d.size()) ? 64'(d[k]) : 64'd0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(out_sum), 64'(exp));
    if (out_ready) begin
      tick();
      chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
      chk({tag, "_ov_after"}, 64'(out_valid), 64'd0);
    end
  endtask

  // Hold off the result for n cycles, then release it.
  task automatic stall(input string tag, input int n,
                       input logic [SW-1:0] exp);
    for (int c = 0; c < n; c++) begin
      tick();
      chk({tag, "_bp_ov"}, 64'(out_valid), 64'd1);
      chk({tag, "_bp_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, "_bp_sum"}, 64'(out_sum), 64'(exp));
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_bp_rel"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    op_q_t         q;
    logic [SW-1:0] e;
    int            gap;
    int            hold;
    int            n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef ADDER_TREE_LOADER_FLUSH_EN
    in_last   = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_ops", 64'(|ops), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Operands 1..8, continuous.
    q = {};
    for (int i = 1; i <= 8; i++) q.push_back(W'(i));
    run_group("seq", q, 0, 1'b0, e);
    chk("seq_36", 64'(e), 64'd36);

    // Full-scale operands, no overflow.
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(W'(23'h7FFFFF));
    run_group("max", q, 0, 1'b0, e);
    chk("max_val", 64'(out_sum), 64'h3FFFFF8);

    // Backpressure for 10 cycles, then a group of ones.
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(W'(i * 3 + 5));
    out_ready = 1'b0;
    run_group("bp", q, 0, 1'b0, e);
    stall("bp", 10, e);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(W'(1));
    run_group("ones", q, 0, 1'b0, e);
    chk("ones_8", 64'(out_sum), 64'd8);

    // Reset after 5 operands discards them.
    for (int i = 0; i < 5; i++) push(W'(100 + i), 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_rdy", 64'(in_ready), 64'd0);
    chk("mid_rst_ops", 64'(|ops), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy", 64'(in_ready), 64'd1);
    chk("mid_rel_ov", 64'(out_valid), 64'd0);
    repeat (4) tick();
    chk("mid_idle_ov", 64'(out_valid), 64'd0);
    q = {};
    for (int i = 1; i <= 8; i++) q.push_back(W'(10 * i));
    run_group("tens", q, 0, 1'b0, e);
    chk("tens_360", 64'(out_sum), 64'd360);

    // in_valid toggling every other cycle.
    q = {};
    for (int i = 1; i <= 8; i++) q.push_back(W'(2 * i));
    run_group("tog", q, 1, 1'b0, e);
    chk("tog_72", 64'(out_sum), 64'd72);

`ifdef ADDER_TREE_LOADER_FLUSH_EN
    // Short group terminated by in_last.
    q = {};
    q.push_back(W'(5));
    q.push_back(W'(6));
    q.push_back(W'(7));
    run_group("flush", q, 0, 1'b1, e);
    chk("flush_18", 64'(out_sum), 64'd18);
`endif

    // Randomized groups with random gaps and stalls.
    for (int g = 0; g < 8; g++) begin
      q   = {};
      n   = 8;
`ifdef ADDER_TREE_LOADER_FLUSH_EN
      n   = $urandom_range(1, 8);
`endif
      for (int i = 0; i < n; i++) q.push_back(W'($urandom));
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 4);
      out_ready = (hold == 0);
      run_group("rnd", q, gap, n < 8, e);
      if (hold != 0) stall("rnd", hold, e);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_loader.md
# adder_tree_loader

Operand loader and result collector for the 8-input pipelined adder tree. Accepts operands one per cycle over a valid/ready stream and presents them as one parallel 8-lane bundle to the tree. Waits out the tree's fixed pipeline latency, then captures the full-precision sum and returns it over a second valid/ready stream. It is the serial-side counterpart of the tree, used wherever operands arrive serially.

## Interface
- `WIDTH`, 23: operand width in bits; matches the tree's adder width.
- `LANES`, 8: tree lanes. Fixed at 8; any other value is a parameter error.
- `TREE_LAT`, 2: cycles from the bundle-launch edge to a valid tree sum (tree input register plus sum register).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand stream valid.
- `in_ready` out 1: operand stream ready.
- `in_data` in WIDTH: operand (unsigned).
- `ops` out LANES*WIDTH: operand bundle to the tree. Lane k occupies bits [k*WIDTH +: WIDTH]; lane 0 is the first operand accepted.
- `tree_sum` in WIDTH+3: full-precision sum from the tree.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result accept.
- `out_sum` out WIDTH+3: captured sum.

## Operation
- State machine:
  - FILL: `in_ready`=1. Each handshake (`in_valid` && `in_ready`) writes lane `cnt` and increments `cnt` (3 bits). The handshake at `cnt`=7 goes to LAUNCH.
  - LAUNCH: one cycle. `ops` is complete and stable. `wcnt` is cleared. Next state is WAIT.
  - WAIT: `wcnt` increments each cycle. When `wcnt`==TREE_LAT-1, `tree_sum` is captured into `out_sum` and the state moves to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, go to FILL, clear `cnt`, and clear all lanes to 0.
- `ops` holds its value from the last FILL write through HOLD. The tree samples every cycle, so the bundle must not change until capture.
- `in_ready`=0 in LAUNCH, WAIT and HOLD. Groups never overlap.
- Arithmetic: none in the block. `out_sum` is a straight copy of `tree_sum` (WIDTH+3 bits, no truncation). The maximum sum is 8·(2^WIDTH−1) < 2^(WIDTH+3).
- Reset values: `in_ready`=0 while `rst_n`=0, then 1 (FILL) from the first cycle after release. `out_valid`=0, `out_sum`=0, `ops`=0, `cnt`=0, `wcnt`=0.
- Reset mid-operation discards any partial group or pending result. There is no output after release until a new full group is loaded.
- `in_valid` while not in FILL is ignored; the data is not consumed.

## Timing
- Let the 8th operand handshake occur at the edge ending cycle N. Then:
  - LAUNCH occupies cycle N+1.
  - The tree sum is valid in cycle N+1+TREE_LAT and is captured at the end of that cycle.
  - `out_valid` rises in cycle N+TREE_LAT+2 (cycle N+4 with the default).
- If `out_ready` is high in the first HOLD cycle, the transfer occurs in that cycle. `in_ready` is 1 in the next cycle.
- Minimum group period: 8 + 1 + TREE_LAT + 1 = 12 cycles with the default.
- `out_ready` held low keeps `out_valid` and `out_sum` stable indefinitely.

## Configuration
- `ADDER_TREE_LOADER_FLUSH_EN` defined:
  - Adds input port `in_last` (1 bit), qualified by the input handshake.
  - A handshake with `in_last`=1 and `cnt`<7 writes that lane and goes to LAUNCH. The unwritten lanes remain 0.
  - `in_last` at `cnt`=7 behaves like a normal 8th operand.
- Not defined: the port is absent and every group is exactly 8 operands.

## Structure
- Shared package `adder_tree_pkg`:
  - state enum {FILL, LAUNCH, WAIT, HOLD}
  - `TREE_LANES`=8
  - `SUM_EXTRA`=3, i.e. log2 of the lane count
- No sub-module. The lane registers, counters and FSM are a single module.
- The bench's tree model is an input register, then an 8-way add, then a sum register; it needs no truncation.

## Test plan
- Operands 1..8 with `in_valid` continuous and `out_ready`=1 → `out_sum`=36. `out_valid` asserted exactly 4 cycles after the 8th handshake. `ops` lane 0 = 1 and lane 7 = 8.
- Eight operands of 0x7FFFFF → `out_sum`=0x3FFFFF8, with no overflow.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → `out_sum` stable and `in_ready`=0 throughout. Release → `in_ready`=1 on the next cycle, and a following group 8×1 gives 8.
- `rst_n` pulsed low after 5 operands → after release, `in_ready`=1 and `out_valid`=0. A new group 10,20,…,80 gives 360, with no contamination from the earlier operands.
- `in_valid` toggling every other cycle with operands 2,4,…,16 → 72. Only handshake cycles count.
- With `ADDER_TREE_LOADER_FLUSH_EN`: operands 5,6,7 with `in_last` on 7 → `out_sum`=18, lanes 3–7 are 0, and `out_valid` is asserted 4 cycles after the last handshake.
